// File: rtl/wb_slave_mem.sv
// ---------------------------------------------------------------------------
// wb_slave_mem -- Wishbone B3 classic-cycle memory slave.
//
// A word-addressed 32-bit memory that terminates each request with ACK, ERR
// or RTY after WAIT_STATES extra cycles. Byte lanes are honoured on writes
// and masked on reads. The request tag is echoed with the response.
// Addresses with any bit set above the memory window get ERR.
//
// Optional feature macro: WB_SLAVE_RTY_EN
//   When defined, every RTY_EVERY-th in-range transfer is answered with RTY
//   instead of ACK and leaves memory untouched. When undefined, RTY_O stays 0.
//
// Parameters
//   aw          address bus width
//   MEM_AW      log2 of memory depth in 32-bit words
//   WAIT_STATES extra cycles before the response (0..15)
//   RTY_EVERY   retry period (>= 2), used only with WB_SLAVE_RTY_EN
//
// Ports
//   CLK_I   clock, rising edge
//   RST_I   asynchronous active-low reset
//   ADR_I   byte address, bits [1:0] ignored
//   DAT_I   write data
//   SEL_I   byte enables
//   WE_I    1 = write, 0 = read
//   CYC_I   bus cycle valid
//   STB_I   transfer strobe
//   TAG_I   transfer tag, captured with the request
//   DAT_O   read data, non-zero only during a read ACK
//   TAG_O   captured tag during any response, else 0
//   ACK_O   normal termination
//   ERR_O   error termination (address out of range)
//   RTY_O   retry termination
// ---------------------------------------------------------------------------
module wb_slave_mem #(
    parameter int aw          = 32,
    parameter int MEM_AW      = 8,
    parameter int WAIT_STATES = 0,
    parameter int RTY_EVERY   = 4
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [aw-1:0] ADR_I,
    input  logic [31:0]   DAT_I,
    input  logic [3:0]    SEL_I,
    input  logic          WE_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic [3:0]    TAG_I,
    output logic [31:0]   DAT_O,
    output logic [3:0]    TAG_O,
    output logic          ACK_O,
    output logic          ERR_O,
    output logic          RTY_O
);

    localparam int          DEPTH     = 1 << MEM_AW;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [15:0] RTY_LAST  = 16'(RTY_EVERY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Expand the four byte enables into a 32-bit data mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    logic [3:0]        wcnt_r;
    logic [MEM_AW-1:0] idx_r;
    logic              in_range_r;
    logic              we_r;
    logic [3:0]        sel_r;
    logic [3:0]        tag_r;
    logic [31:0]       wdat_r;
    logic [31:0]       mem_r [0:DEPTH-1];

    logic              bus_req_s;
    logic              resp_busy_s;
    logic              in_range_s;
    logic              capture_s;
    logic              fire_s;
    logic              rty_slot_s;
    logic              ack_nx_s;
    logic              err_nx_s;
    logic              rty_nx_s;
    logic [31:0]       dat_nx_s;
    logic [3:0]        tag_nx_s;
    logic              mem_we_s;
    logic              unused_s;

    assign bus_req_s   = CYC_I & STB_I;
    // While a response is on the outputs the master still holds the old
    // request; it must not be taken as a new one.
    assign resp_busy_s = ACK_O | ERR_O | RTY_O;
    assign in_range_s  = (ADR_I[aw-1:MEM_AW+2] == {(aw-MEM_AW-2){1'b0}});
    assign capture_s   = (state_r == ST_IDLE) & bus_req_s & ~resp_busy_s;
    // The response is decided in RESP and only if the master is still there;
    // a dropped strobe at this edge is an abort.
    assign fire_s      = (state_r == ST_RESP) & bus_req_s;

    // State register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE, aborting on strobe loss.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    if (WAIT_STATES > 0) begin
                        state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_RESP;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus_req_s) begin
                    state_nx_s = ST_IDLE;
                end else if (wcnt_r <= 4'd1) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Request capture and wait-state countdown; later input changes are ignored.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wcnt_r     <= 4'd0;
            idx_r      <= {MEM_AW{1'b0}};
            in_range_r <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= 4'd0;
            tag_r      <= 4'd0;
            wdat_r     <= 32'd0;
        end else if (capture_s) begin
            wcnt_r     <= WAIT_INIT;
            idx_r      <= ADR_I[MEM_AW+1:2];
            in_range_r <= in_range_s;
            we_r       <= WE_I;
            sel_r      <= SEL_I;
            tag_r      <= TAG_I;
            wdat_r     <= DAT_I;
        end else if (state_r == ST_WAIT) begin
            wcnt_r <= wcnt_r - 4'd1;
        end
    end

`ifdef WB_SLAVE_RTY_EN
    logic [15:0] rty_cnt_r;

    // The counter is checked before it advances, so the RTY_EVERY-th
    // in-range transfer is the one that is retried.
    assign rty_slot_s = (rty_cnt_r == RTY_LAST);
    assign unused_s   = ^ADR_I[1:0];

    // Retry period counter; only in-range transfers that respond advance it.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            rty_cnt_r <= 16'd0;
        end else if (fire_s && in_range_r) begin
            if (rty_slot_s) begin
                rty_cnt_r <= 16'd0;
            end else begin
                rty_cnt_r <= rty_cnt_r + 16'd1;
            end
        end
    end
`else
    assign rty_slot_s = 1'b0;
    assign unused_s   = ^{ADR_I[1:0], RTY_LAST};
`endif

    // Output decode: choose the termination and the values to register.
    always_comb begin
        ack_nx_s = 1'b0;
        err_nx_s = 1'b0;
        rty_nx_s = 1'b0;
        dat_nx_s = 32'd0;
        tag_nx_s = 4'd0;
        if (fire_s) begin
            if (!in_range_r) begin
                err_nx_s = 1'b1;
            end else if (rty_slot_s) begin
                rty_nx_s = 1'b1;
            end else begin
                ack_nx_s = 1'b1;
            end
            tag_nx_s = tag_r;
        end else begin
            tag_nx_s = 4'd0;
        end
        if (ack_nx_s && !we_r) begin
            dat_nx_s = mem_r[idx_r] & lane_mask(sel_r);
        end else begin
            dat_nx_s = 32'd0;
        end
    end

    assign mem_we_s = ack_nx_s & we_r;

    // Registered bus outputs; each response lasts exactly one cycle.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            RTY_O <= 1'b0;
            DAT_O <= 32'd0;
            TAG_O <= 4'd0;
        end else begin
            ACK_O <= ack_nx_s;
            ERR_O <= err_nx_s;
            RTY_O <= rty_nx_s;
            DAT_O <= dat_nx_s;
            TAG_O <= tag_nx_s;
        end
    end

    // Memory array: byte-lane writes on ACKed writes only, contents survive reset.
    always_ff @(posedge CLK_I) begin
        for (int n = 0; n < 4; n++) begin
            if (mem_we_s && sel_r[n]) begin
                mem_r[idx_r][8*n +: 8] <= wdat_r[8*n +: 8];
            end
        end
    end

endmodule
